// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one registered single-beat memory bus between
// the instruction cache (master 0) and the data cache (master 1).
module mem_bus_arbiter #(
  parameter logic [2:0] BR_READ   = 3'd1,
  parameter logic [2:0] BR_WRITE  = 3'd2,
  parameter int         HOLD      = 2,
  parameter int         MAX_BEATS = 8
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic [31:0] M0_A,
  input  logic [31:0] M1_A,
  input  logic [2:0]  M0_BR,
  input  logic [2:0]  M1_BR,
  input  logic [1:0]  M0_SIZ,
  input  logic [1:0]  M1_SIZ,
  input  logic [31:0] M0_WD,
  input  logic [31:0] M1_WD,
  output logic [31:0] M0_RD,
  output logic [31:0] M1_RD,
  output logic        M0_COMPL,
  output logic        M1_COMPL,
  output logic [1:0]  GNT,
  output logic [31:0] B_A,
  output logic [2:0]  B_BR,
  output logic [1:0]  B_SIZ,
  output logic [31:0] B_WD,
  input  logic [31:0] B_RD,
  input  logic        B_COMPL
);

  localparam logic [3:0] HOLD_C = 4'(HOLD);
  localparam logic [3:0] MAX_C  = 4'(MAX_BEATS);

  typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_BUSY, ST_DONE} state_t;

  state_t state, nxt;
  logic [1:0][31:0] m_a, m_wd, rd_q;
  logic [1:0][2:0]  m_br;
  logic [1:0][1:0]  m_siz;
  logic [1:0]       req, compl_q;
  logic             last;          // current/most recent owner
  logic [3:0]       idle_cnt, beat_cnt;
  logic             cap, cap_m, rel, idle_inc, cmp;

  assign m_a   = {M1_A, M0_A};
  assign m_wd  = {M1_WD, M0_WD};
  assign m_br  = {M1_BR, M0_BR};
  assign m_siz = {M1_SIZ, M0_SIZ};

  for (genvar i = 0; i < 2; i++) begin : g_req
    assign req[i] = (m_br[i] == BR_READ) || (m_br[i] == BR_WRITE);
  end

  assign M0_RD    = rd_q[0];
  assign M1_RD    = rd_q[1];
  assign M0_COMPL = compl_q[0];
  assign M1_COMPL = compl_q[1];

  always_comb begin
    nxt      = state;
    cap      = 1'b0;
    cap_m    = last;
    rel      = 1'b0;
    idle_inc = 1'b0;
    cmp      = 1'b0;
    case (state)
      ST_IDLE: if (|req) begin
        cap   = 1'b1;
        cap_m = (&req) ? ~last : req[1];
        nxt   = ST_BUSY;
      end
      ST_OWN: begin
        // the tenure cap beats a pending owner request
        if (beat_cnt == MAX_C && req[~last]) begin
          rel = 1'b1;
          nxt = ST_IDLE;
        end else if (req[last]) begin
          cap = 1'b1;
          nxt = ST_BUSY;
        end else begin
          idle_inc = 1'b1;
          if (idle_cnt + 4'd1 == HOLD_C) begin
            rel = 1'b1;
            nxt = ST_IDLE;
          end
        end
      end
      ST_BUSY: if (B_COMPL) begin
        cmp = 1'b1;
        nxt = ST_DONE;
      end
      ST_DONE: nxt = ST_OWN;
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (nRESET) begin
      state    <= ST_IDLE;
      last     <= 1'b1;
      idle_cnt <= '0;
      beat_cnt <= '0;
      GNT      <= '0;
      B_A      <= '0;
      B_BR     <= '0;
      B_SIZ    <= '0;
      B_WD     <= '0;
      rd_q     <= '0;
      compl_q  <= '0;
    end else begin
      state   <= nxt;
      compl_q <= '0;
      if (cap) begin
        B_A      <= m_a[cap_m];
        B_BR     <= m_br[cap_m];
        B_SIZ    <= m_siz[cap_m];
        B_WD     <= m_wd[cap_m];
        idle_cnt <= '0;
        if (state == ST_IDLE) begin
          last     <= cap_m;
          beat_cnt <= '0;
          GNT      <= cap_m ? 2'b10 : 2'b01;
        end
      end
      if (idle_inc) idle_cnt <= idle_cnt + 4'd1;
      if (rel)      GNT      <= '0;
      if (cmp) begin
        B_BR          <= '0;
        rd_q[last]    <= B_RD;
        compl_q[last] <= 1'b1;
        if (beat_cnt != MAX_C) beat_cnt <= beat_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scenarios followed by randomized two-master traffic against a
// transaction-level memory model with per-master address regions.
module tb_mem_bus_arbiter;
  logic        CLK = 1'b0, nRESET;
  logic [31:0] M0_A, M1_A, M0_WD, M1_WD, M0_RD, M1_RD, B_A, B_WD, B_RD;
  logic [2:0]  M0_BR, M1_BR, B_BR;
  logic [1:0]  M0_SIZ, M1_SIZ, B_SIZ, GNT;
  logic        M0_COMPL, M1_COMPL, B_COMPL;

  mem_bus_arbiter dut (
    .CLK(CLK), .nRESET(nRESET),
    .M0_A(M0_A), .M1_A(M1_A), .M0_BR(M0_BR), .M1_BR(M1_BR),
    .M0_SIZ(M0_SIZ), .M1_SIZ(M1_SIZ), .M0_WD(M0_WD), .M1_WD(M1_WD),
    .M0_RD(M0_RD), .M1_RD(M1_RD), .M0_COMPL(M0_COMPL), .M1_COMPL(M1_COMPL),
    .GNT(GNT), .B_A(B_A), .B_BR(B_BR), .B_SIZ(B_SIZ), .B_WD(B_WD),
    .B_RD(B_RD), .B_COMPL(B_COMPL)
  );

  always #5 CLK = ~CLK;

  int total = 0, fails = 0;
  localparam int N = 30;

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // random-phase state: model memory, slave memory, per-master transaction
  logic [31:0] refm [32];
  logic [31:0] mem  [32];
  logic [31:0] slv_ret;
  int op [2], idx [2], gap [2], done [2];
  logic [31:0] wd [2];

  task automatic new_txn(input int m);
    op[m]  = ($urandom_range(0, 1) == 0) ? 1 : 2;
    idx[m] = m * 16 + int'($urandom_range(0, 15));
    wd[m]  = $urandom;
    gap[m] = int'($urandom_range(0, 3));
  endtask

  task automatic drive();
    M0_BR = (gap[0] > 0 || done[0] >= N) ? 3'd0 : 3'(op[0]);
    M1_BR = (gap[1] > 0 || done[1] >= N) ? 3'd0 : 3'(op[1]);
    M0_A  = 32'(idx[0] * 4);  M1_A  = 32'(idx[1] * 4);
    M0_WD = wd[0];            M1_WD = wd[1];
  endtask

  initial begin
    int m1_pulses, cyc, own;
    logic [31:0] exp_rd;
    logic [1:0] cmpl;
    {M0_A, M1_A, M0_WD, M1_WD, B_RD} = '0;
    {M0_BR, M1_BR, M0_SIZ, M1_SIZ, B_COMPL} = '0;
    nRESET = 1'b1;
    step(); step();
    chk("rst_gnt", 32'(GNT), 0);
    chk("rst_bbr", 32'(B_BR), 0);
    chk("rst_ba", B_A, 0);
    chk("rst_rd", M0_RD | M1_RD, 0);
    chk("rst_compl", 32'({M0_COMPL, M1_COMPL}), 0);

    // tie on first cycle after reset, then a 4-beat line fill for master 0
    nRESET = 1'b0;
    M0_BR = 3'd1; M0_A = 32'h100; M1_BR = 3'd1; M1_A = 32'h2000;
    step();
    for (int k = 0; k < 4; k++) begin
      chk("fill_gnt", 32'(GNT), 1);
      chk("fill_addr", B_A, 32'h100 + 32'(4 * k));
      B_COMPL = 1'b1; B_RD = 32'(k) + 32'hA0;
      step();
      chk("fill_compl0", 32'(M0_COMPL), 1);
      chk("fill_compl1", 32'(M1_COMPL), 0);
      chk("fill_rd", M0_RD, 32'(k) + 32'hA0);
      chk("fill_bbr0", 32'(B_BR), 0);
      B_COMPL = 1'b0;
      if (k < 3) M0_A = 32'h100 + 32'(4 * (k + 1)); else M0_BR = 3'd0;
      step();
      chk("fill_pulse_end", 32'(M0_COMPL), 0);
      if (k < 3) step();
    end
    step();
    chk("hold_gnt", 32'(GNT), 1);
    step();
    chk("release_gnt", 32'(GNT), 0);
    step();
    chk("m1_gnt", 32'(GNT), 2);
    chk("m1_addr", B_A, 32'h2000);
    B_COMPL = 1'b1; B_RD = 32'h5A5A;
    step();
    chk("m1_compl", 32'(M1_COMPL), 1);
    chk("m1_rd", M1_RD, 32'h5A5A);
    B_COMPL = 1'b0; M1_BR = 3'd0;
    step(); step(); step();
    chk("m1_release", 32'(GNT), 0);

    // single read
    M0_BR = 3'd1; M0_A = 32'h00001230;
    step();
    chk("sr_addr", B_A, 32'h00001230);
    chk("sr_bbr", 32'(B_BR), 1);
    chk("sr_gnt", 32'(GNT), 1);
    step(); step();
    chk("sr_hold", 32'(B_BR), 1);
    B_COMPL = 1'b1; B_RD = 32'hDEADBEEF;
    step();
    chk("sr_compl", 32'(M0_COMPL), 1);
    chk("sr_rd", M0_RD, 32'hDEADBEEF);
    chk("sr_bbr0", 32'(B_BR), 0);
    chk("sr_m1rd_held", M1_RD, 32'h5A5A);
    B_COMPL = 1'b0; M0_BR = 3'd0;
    step(); step(); step();
    chk("sr_release", 32'(GNT), 0);

    // starvation cap: master 1 streams writes while master 0 waits
    M1_BR = 3'd2; M1_A = 32'h80; M1_WD = 32'h11111111;
    step();
    M0_BR = 3'd1; M0_A = 32'h300;
    m1_pulses = 0;
    for (int k = 0; k < 8; k++) begin
      chk("sc_gnt", 32'(GNT), 2);
      chk("sc_wd", B_WD, 32'h11111111);
      B_COMPL = 1'b1;
      step(); m1_pulses += int'(M1_COMPL);
      B_COMPL = 1'b0;
      step(); m1_pulses += int'(M1_COMPL);
      if (k < 7) begin step(); m1_pulses += int'(M1_COMPL); end
    end
    step();
    chk("sc_release", 32'(GNT), 0);
    step();
    chk("sc_m0_gnt", 32'(GNT), 1);
    chk("sc_m0_addr", B_A, 32'h300);
    chk("sc_pulses", 32'(m1_pulses), 8);
    B_COMPL = 1'b1;
    step();
    B_COMPL = 1'b0; M0_BR = 3'd0; M1_BR = 3'd0;
    step(); step(); step();

    // reset while a write is outstanding
    M1_BR = 3'd2; M1_A = 32'h40;
    step();
    chk("mr_busy", 32'(B_BR), 2);
    nRESET = 1'b1;
    step();
    chk("mr_bbr", 32'(B_BR), 0);
    chk("mr_gnt", 32'(GNT), 0);
    chk("mr_compl", 32'({M0_COMPL, M1_COMPL}), 0);
    nRESET = 1'b0; M1_BR = 3'd0; B_COMPL = 1'b1;
    step();
    chk("mr_late_compl", 32'({M0_COMPL, M1_COMPL}), 0);
    B_COMPL = 1'b0;
    step();
    chk("mr_late_compl2", 32'({M0_COMPL, M1_COMPL}), 0);

    // invalid request code
    M1_BR = 3'd5;
    step(); step();
    chk("inv_gnt", 32'(GNT), 0);
    chk("inv_bbr", 32'(B_BR), 0);
    M1_BR = 3'd0;

    // randomized traffic
    for (int i = 0; i < 32; i++) begin
      refm[i] = 32'(i) * 32'h01010101;
      mem[i]  = refm[i];
    end
    done[0] = 0; done[1] = 0;
    new_txn(0); new_txn(1);
    M0_SIZ = 2'b10; M1_SIZ = 2'b10;
    cyc = 0;
    while ((done[0] < N || done[1] < N) && cyc < 8000) begin
      drive();
      step(); cyc++;
      cmpl = {M1_COMPL, M0_COMPL};
      if (cmpl == 2'b11) chk("rnd_both_compl", 32'(cmpl), 0);
      for (int m = 0; m < 2; m++) begin
        if (cmpl[m]) begin
          exp_rd = (op[m] == 1) ? refm[idx[m]] : slv_ret;
          chk(m == 0 ? "rnd_rd0" : "rnd_rd1", m == 0 ? M0_RD : M1_RD, exp_rd);
          if (op[m] == 2) refm[idx[m]] = wd[m];
          done[m]++;
          new_txn(m);
        end else if (gap[m] > 0) gap[m]--;
      end
      if (B_COMPL) B_COMPL = 1'b0;
      else if (B_BR != 3'd0 && $urandom_range(0, 2) == 0) begin
        own = int'(GNT[1]);
        chk("rnd_gnt_onehot", 32'(GNT == 2'b01 || GNT == 2'b10), 1);
        chk("rnd_bus_addr", B_A, 32'(idx[own] * 4));
        chk("rnd_bus_br", 32'(B_BR), 32'(op[own]));
        if (B_BR == 3'd1) B_RD = mem[B_A[6:2]];
        else begin
          B_RD = $urandom;
          mem[B_A[6:2]] = B_WD;
        end
        slv_ret = B_RD;
        B_COMPL = 1'b1;
      end
    end
    chk("rnd_done0", 32'(done[0]), N);
    chk("rnd_done1", 32'(done[1]), N);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
